fetch_decode: RTL and testbench

FETCH_DECODE -- requirements
Module: fetch_decode

---
 rtl/fetch_decode.sv | 97 +++++++++
 tb/tb_fetch_decode.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_decode.sv
// Purpose: program counter driven fetch stage with a one-entry decoded output register.
// Latency: one cycle from instruction_address to the registered decoded fields.
// Backpressure: out_valid && !out_ready freezes pc and outputs; accept plus load gives one instruction per cycle.
//
// Ports:
//   clk, rst_n            single clock, synchronous active-low reset
//   enable                permits new fetches while high
//   instruction_address   current pc, drives program memory
//   instruction           combinational read data for instruction_address
//   out_valid/out_ready   handshake for the held decoded instruction
//   opcode/reg_sel/operand/out_pc/is_alu/is_load/is_store  held decode result
//   illegal               sticky, set when an opcode 0x8-0xE is fetched
//   halted                program finished (or illegal) and output drained
module fetch_decode #(
    parameter int BITS_FOR_INSTRUCTIONS  = 5,
    parameter int INSTRUCTION_WIDTH      = 16,
    parameter int NUMBER_OF_INSTRUCTIONS = 32
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             enable,
    output logic [BITS_FOR_INSTRUCTIONS-1:0] instruction_address,
    input  logic [INSTRUCTION_WIDTH-1:0]     instruction,
    output logic                             out_valid,
    input  logic                             out_ready,
    output logic [3:0]                       opcode,
    output logic [1:0]                       reg_sel,
    output logic [9:0]                       operand,
    output logic [BITS_FOR_INSTRUCTIONS-1:0] out_pc,
    output logic                             is_alu,
    output logic                             is_load,
    output logic                             is_store,
    output logic                             illegal,
    output logic                             halted
);

    typedef enum logic {RUN, HALT} state_t;

    localparam logic [BITS_FOR_INSTRUCTIONS-1:0] LAST_PC =
        BITS_FOR_INSTRUCTIONS'(NUMBER_OF_INSTRUCTIONS - 1);
    localparam logic [3:0] OP_NOP = 4'hF;

    state_t                           state;
    logic [BITS_FOR_INSTRUCTIONS-1:0] pc;
    logic                             load;
    logic [3:0]                       op_in;

    assign instruction_address = pc;
    assign op_in               = instruction[15:12];

    // A fetch happens only when the output register is free or being drained this edge.
    assign load   = (state == RUN) && enable && (!out_valid || out_ready);
    assign halted = (state == HALT) && !out_valid;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pc        <= '0;
            state     <= RUN;
            out_valid <= 1'b0;
            opcode    <= '0;
            reg_sel   <= '0;
            operand   <= '0;
            out_pc    <= '0;
            is_alu    <= 1'b0;
            is_load   <= 1'b0;
            is_store  <= 1'b0;
            illegal   <= 1'b0;
        end else if (load) begin
            // pc simply increments; after the last word the state is HALT so the
            // truncated address is never fetched.
            pc <= pc + 1'b1;
            if (!op_in[3]) begin
                opcode    <= op_in;
                reg_sel   <= instruction[11:10];
                operand   <= instruction[9:0];
                out_pc    <= pc;
                is_alu    <= (op_in <= 4'h5);
                is_load   <= (op_in == 4'h6);
                is_store  <= (op_in == 4'h7);
                out_valid <= 1'b1;
            end else if (op_in == OP_NOP) begin
                // NOPs are swallowed: fields keep their previous contents.
                out_valid <= 1'b0;
            end else begin
                out_valid <= 1'b0;
                illegal   <= 1'b1;
                state     <= HALT;
            end
            if (pc == LAST_PC) begin
                state <= HALT;
            end
        end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_fetch_decode.sv
module tb_fetch_decode;

    typedef struct packed {
        logic [3:0] opcode;
        logic [1:0] reg_sel;
        logic [9:0] operand;
        logic [4:0] pc;
        logic       alu;
        logic       ld;
        logic       st;
    } beat_t;

    typedef struct {
        logic [15:0] instr;
        logic        exp_valid;
        logic        exp_ill;
        logic        exp_halt;
        beat_t       exp;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        enable = 1'b0;
    logic        out_ready = 1'b0;
    logic [4:0]  instruction_address;
    logic [15:0] instruction;
    logic        out_valid;
    logic [3:0]  opcode;
    logic [1:0]  reg_sel;
    logic [9:0]  operand;
    logic [4:0]  out_pc;
    logic        is_alu, is_load, is_store, illegal, halted;

    logic [15:0] mem [0:31];
    beat_t       sb_q [$];
    logic        sb_on = 1'b0;
    int          n_checks = 0;
    int          n_pass = 0;
    int          beats = 0;

    always #5 clk = ~clk;

    assign instruction = mem[instruction_address];

    fetch_decode #(
        .BITS_FOR_INSTRUCTIONS(5),
        .INSTRUCTION_WIDTH(16),
        .NUMBER_OF_INSTRUCTIONS(32)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .enable(enable),
        .instruction_address(instruction_address),
        .instruction(instruction),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .opcode(opcode),
        .reg_sel(reg_sel),
        .operand(operand),
        .out_pc(out_pc),
        .is_alu(is_alu),
        .is_load(is_load),
        .is_store(is_store),
        .illegal(illegal),
        .halted(halted)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    function automatic beat_t mk(input logic [3:0] op, input logic [1:0] rs, input logic [9:0] opd,
                                 input logic [4:0] pc);
        beat_t b;
        b.opcode  = op;
        b.reg_sel = rs;
        b.operand = opd;
        b.pc      = pc;
        b.alu     = (op <= 4'h5);
        b.ld      = (op == 4'h6);
        b.st      = (op == 4'h7);
        return b;
    endfunction

    function automatic beat_t cur();
        return {opcode, reg_sel, operand, out_pc, is_alu, is_load, is_store};
    endfunction

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic fill(input logic [15:0] w);
        for (int i = 0; i < 32; i++) mem[i] = w;
    endtask

    // Reset for one edge; checks are made while rst_n is still low.
    task automatic do_reset(input logic en, input logic rdy, input logic chk);
        rst_n = 1'b0;
        enable = en;
        out_ready = rdy;
        tick();
        if (chk) begin
            check("rst_valid", out_valid, 0);
            check("rst_fields", cur(), 0);
            check("rst_pc", instruction_address, 0);
            check("rst_illegal", illegal, 0);
            check("rst_halted", halted, 0);
        end
        rst_n = 1'b1;
    endtask

    // Scoreboard monitor: every accepted beat must match the head of the queue.
    always begin
        @(negedge clk);
        #1;
        if (sb_on && out_valid && out_ready) begin
            if (sb_q.size() == 0) begin
                check("sb_extra_beat", 1, 0);
            end else begin
                check("sb_beat", cur(), sb_q.pop_front());
                beats++;
            end
        end
    end

    vec_t vecs [8];

    initial begin
        vecs[0] = '{16'h0000, 1, 0, 0, mk(4'h0, 2'd0, 10'h000, 5'd0)};
        vecs[1] = '{16'h5ABC, 1, 0, 0, mk(4'h5, 2'd2, 10'h2BC, 5'd0)};
        vecs[2] = '{16'h6000, 1, 0, 0, mk(4'h6, 2'd0, 10'h000, 5'd0)};
        vecs[3] = '{16'h73FF, 1, 0, 0, mk(4'h7, 2'd0, 10'h3FF, 5'd0)};
        vecs[4] = '{16'hF000, 0, 0, 0, beat_t'(0)};
        vecs[5] = '{16'h9123, 0, 1, 1, beat_t'(0)};
        vecs[6] = '{16'hE000, 0, 1, 1, beat_t'(0)};
        vecs[7] = '{16'h8FFF, 0, 1, 1, beat_t'(0)};

        // Reset state.
        fill(16'hF000);
        @(negedge clk);
        do_reset(1'b1, 1'b1, 1'b1);

        // Single-word decode table, downstream stalled so the result stays put.
        for (int v = 0; v < 8; v++) begin
            fill(16'hF000);
            mem[0] = vecs[v].instr;
            do_reset(1'b1, 1'b0, 1'b0);
            tick();
            check($sformatf("vec%0d_valid", v), out_valid, vecs[v].exp_valid);
            check($sformatf("vec%0d_illegal", v), illegal, vecs[v].exp_ill);
            check($sformatf("vec%0d_halted", v), halted, vecs[v].exp_halt);
            check($sformatf("vec%0d_fields", v), cur(), vecs[v].exp);
            check($sformatf("vec%0d_pc", v), instruction_address, 1);
        end

        // NOP skip, then LOAD stalled two cycles, then STORE.
        fill(16'hF000);
        mem[1] = 16'h0000;
        mem[2] = 16'h6000;
        mem[3] = 16'h7400;
        do_reset(1'b1, 1'b1, 1'b0);
        tick();
        check("nop_valid", out_valid, 0);
        check("nop_pc", instruction_address, 1);
        tick();
        check("alu_valid", out_valid, 1);
        check("alu_fields", cur(), mk(4'h0, 2'd0, 10'h0, 5'd1));
        check("alu_pc", instruction_address, 2);
        tick();
        check("ld_fields", cur(), mk(4'h6, 2'd0, 10'h0, 5'd2));
        out_ready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            tick();
            check("ld_hold_valid", out_valid, 1);
            check("ld_hold_fields", cur(), mk(4'h6, 2'd0, 10'h0, 5'd2));
            check("ld_hold_pc", instruction_address, 3);
        end
        out_ready = 1'b1;
        tick();
        check("st_valid", out_valid, 1);
        check("st_fields", cur(), mk(4'h7, 2'd1, 10'h0, 5'd3));
        check("st_pc", instruction_address, 4);

        // Illegal opcode halts and freezes until reset.
        fill(16'h0000);
        mem[1] = 16'h9123;
        do_reset(1'b1, 1'b1, 1'b0);
        tick();
        check("pre_ill_valid", out_valid, 1);
        tick();
        check("ill_valid", out_valid, 0);
        check("ill_flag", illegal, 1);
        check("ill_halted", halted, 1);
        check("ill_pc", instruction_address, 2);
        for (int i = 0; i < 6; i++) begin
            enable = i[0];
            out_ready = i[1];
            tick();
        end
        check("ill_frozen_pc", instruction_address, 2);
        check("ill_frozen_valid", out_valid, 0);
        check("ill_frozen_flag", illegal, 1);
        check("ill_frozen_halted", halted, 1);
        do_reset(1'b1, 1'b1, 1'b0);
        check("ill_cleared", {illegal, halted}, 0);

        // Full program of ALU words: 32 back-to-back beats then HALT.
        fill(16'h0000);
        do_reset(1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 32; i++) sb_q.push_back(mk(4'h0, 2'd0, 10'h0, 5'(i)));
        beats = 0;
        sb_on = 1'b1;
        enable = 1'b1;
        tick();
        for (int i = 0; i < 32; i++) begin
            check("full_stream_valid", out_valid, 1);
            tick();
        end
        check("full_halted", halted, 1);
        check("full_addr", instruction_address, 0);
        check("full_beats", beats, 32);
        check("full_sb_empty", sb_q.size(), 0);
        tick();
        check("full_no_refetch", {out_valid, instruction_address}, 0);
        sb_on = 1'b0;

        // Mixed program with NOPs and random enable/ready.
        for (int i = 0; i < 32; i++) begin
            if (i % 5 == 3) mem[i] = 16'hF000;
            else mem[i] = {4'(i % 8), 2'(i % 4), 10'(i * 7)};
        end
        do_reset(1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 32; i++)
            if (i % 5 != 3) sb_q.push_back(mk(4'(i % 8), 2'(i % 4), 10'(i * 7), 5'(i)));
        beats = 0;
        sb_on = 1'b1;
        for (int c = 0; c < 600 && !halted; c++) begin
            enable = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 2) != 0);
            tick();
        end
        check("mix_halted", halted, 1);
        check("mix_sb_empty", sb_q.size(), 0);
        check("mix_beats", beats, 26);
        sb_on = 1'b0;

        // Reset during a stall, then enable low only drains.
        fill(16'h0000);
        do_reset(1'b1, 1'b0, 1'b0);
        tick();
        check("stall_valid", out_valid, 1);
        tick();
        rst_n = 1'b0;
        tick();
        check("midrst_valid", out_valid, 0);
        check("midrst_fields", cur(), 0);
        check("midrst_pc", instruction_address, 0);
        rst_n = 1'b1;
        tick();
        check("refetch_valid", out_valid, 1);
        check("refetch_fields", cur(), mk(4'h0, 2'd0, 10'h0, 5'd0));
        check("refetch_pc", instruction_address, 1);
        enable = 1'b0;
        out_ready = 1'b1;
        tick();
        check("drain_valid", out_valid, 0);
        tick();
        check("drain_pc", instruction_address, 1);
        check("drain_halted", halted, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
